// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps every input vector in ascending order, samples fn_in,
// and reports the minterm mask and count and streams each minterm index over valid/ready.
module truth_table_sweeper #(
    parameter int unsigned N_INPUTS      = 5,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic [N_INPUTS-1:0]       vec_out,
    input  logic                      fn_in,
    output logic                      mt_valid,
    input  logic                      mt_ready,
    output logic [N_INPUTS-1:0]       mt_index,
    output logic                      busy,
    output logic                      done,
    output logic [2**N_INPUTS-1:0]    minterm_mask,
    output logic [N_INPUTS:0]         minterm_count
);

    localparam int unsigned CW = N_INPUTS + 1;
    localparam int unsigned SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [SW-1:0]            settle_q, settle_d;
    logic [N_INPUTS-1:0]      vec_d;
    logic [2**N_INPUTS-1:0]   mask_d;
    logic [N_INPUTS:0]        count_d;
    logic                     valid_d, busy_d, done_d;
    logic                     active;

    assign mt_index = vec_out;
    assign active   = (state_q == S_DRIVE) || (state_q == S_SAMPLE) || (state_q == S_EMIT);

    // Next-state and next-output logic; abort overrides everything while a sweep runs.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        vec_d    = vec_out;
        mask_d   = minterm_mask;
        count_d  = minterm_count;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d    = '0;
                    mask_d   = '0;
                    count_d  = '0;
                    settle_d = SW'(SETTLE_CYCLES);
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q <= SW'(1)) state_d = S_SAMPLE;
                else                    settle_d = settle_q - SW'(1);
            end
            S_SAMPLE: begin
                if (fn_in) begin
                    mask_d[vec_out] = 1'b1;
                    count_d         = minterm_count + CW'(1);
                    state_d         = S_EMIT;
                end else if (&vec_out) begin
                    state_d = S_DONE;
                end else begin
                    vec_d    = vec_out + N_INPUTS'(1);
                    settle_d = SW'(SETTLE_CYCLES);
                    state_d  = S_DRIVE;
                end
            end
            S_EMIT: begin
                if (mt_valid && mt_ready) begin
                    if (&vec_out) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d    = vec_out + N_INPUTS'(1);
                        settle_d = SW'(SETTLE_CYCLES);
                        state_d  = S_DRIVE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && active) begin
            state_d  = S_IDLE;
            settle_d = '0;
            vec_d    = '0;
            mask_d   = '0;
            count_d  = '0;
        end
        valid_d = (state_d == S_EMIT);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d == S_DRIVE) || (state_d == S_SAMPLE) || (state_d == S_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            settle_q      <= '0;
            vec_out       <= '0;
            minterm_mask  <= '0;
            minterm_count <= '0;
            mt_valid      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            vec_out       <= vec_d;
            minterm_mask  <= mask_d;
            minterm_count <= count_d;
            mt_valid      <= valid_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule
